pc_control: RTL and testbench
=============================

PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 The block SHALL expose the following ports: clk, rst, stall, halt, branch, ccc, flags, imm_9bit, reg_target, pc, pc_plus2, taken, flush, halted, taken_count.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous reset, active-low; the name follows the codebase, the polarity is fixed.
REQ-004 stall  in  1  freeze PC and ignore branch/halt this cycle.
REQ-005 halt  in  1  HLT instruction decoded at current PC.
REQ-006 branch  in  2  00 none, 01 B (PC-relative), 10 BR (register), 11 treated as none.
REQ-007 ccc  in  3  branch condition code.
REQ-008 flags  in  3  NVZ from execute stage: [2]=N, [1]=V, [0]=Z.
REQ-009 imm_9bit  in  9  signed word offset for B.
REQ-010 reg_target  in  16  target address for BR.
REQ-011 pc  out  16  current fetch address (registered).
REQ-012 pc_plus2  out  16  pc+2 mod 2^16 (combinational from pc), for PCS writeback.
REQ-013 taken  out  1  registered; 1 for one cycle after a taken branch is committed.
REQ-014 flush  out  1  registered; equals taken; tells fetch/decode to squash the wrong-path instruction.
REQ-015 halted  out  1  1 while the FSM is in HALT.
REQ-016 taken_count  out  16  saturating count of taken branches since reset.

Function
REQ-017 The FSM SHALL have two states, RUN and HALT; reset enters RUN.
REQ-018 The condition met SHALL be: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-019 The B target SHALL be pc_plus2 + (sign_extend(imm_9bit) << 1), with 16-bit wrap-around and no error.
REQ-020 The BR target SHALL be reg_target with bit 0 forced to 0.
REQ-021 In RUN with stall=0, the next pc SHALL be: halt=1 -> pc unchanged; branch taken -> target; otherwise pc_plus2.
REQ-022 A taken branch SHALL be branch in {01,10} with the condition met.
REQ-023 A branch SHALL be resolved in the same cycle it is presented; the new pc is visible one cycle later, i.e. single-cycle redirect latency.
REQ-024 taken and flush SHALL assert in the cycle following the edge that loaded the target, and deassert after one cycle unless another branch is taken.
REQ-025 Simultaneous halt and branch SHALL give halt priority: no redirect, no taken, no count.
REQ-026 In RUN with halt=1 and stall=0, the FSM SHALL move to HALT at the next edge.
REQ-027 In HALT, pc SHALL hold and all inputs SHALL be ignored.
REQ-028 In HALT, halted SHALL be 1 and taken/flush SHALL be 0.
REQ-029 HALT SHALL be exited only by reset.
REQ-030 When stall=1, pc, state and taken_count SHALL hold, and taken/flush SHALL be 0 next cycle.
REQ-031 taken_count SHALL increment by 1 per committed taken branch and saturate at 16'hFFFF.
REQ-032 The flags input SHALL be sampled only; flags are owned by the execute stage and never modified by this block.
REQ-033 branch=11 SHALL behave as no branch, advancing pc by 2.

Reset
REQ-034 rst=0 SHALL immediately and asynchronously force pc=16'h0000, state RUN, taken=0, flush=0, halted=0, taken_count=0.
REQ-035 Reset asserted mid-branch or in HALT SHALL discard the pending redirect.
REQ-036 The first edge after rst deasserts SHALL advance pc to 16'h0002 if stall=0 and halt=0.

Verification
REQ-037 Sequential fetch from reset with no branches for 4 cycles -> pc 0000, 0002, 0004, 0006; taken_count=0.
REQ-038 pc=0010, branch=01, ccc=001, flags Z=1, imm_9bit=9'h1FE (-2) -> next pc=000E; taken=flush=1 for one cycle; taken_count=1.
REQ-039 pc=0010, branch=01, ccc=001, Z=0 -> next pc=0012; taken=0.
REQ-040 branch=10, ccc=111, reg_target=1235 -> next pc=1234; pc=FFFE with no branch -> next pc=0000 (wrap).
REQ-041 halt=1 with branch=01, ccc=111 at pc=0020 -> pc stays 0020, halted=1 next cycle, no taken; further stimulus ignored; rst=0 -> pc=0000, halted=0.
REQ-042 stall=1 with branch=01, ccc=111 -> pc holds, taken=0, count unchanged.
REQ-043 Preloaded taken_count=FFFF plus a further taken branch -> taken_count remains FFFF.

Source files
------------

// File: rtl/pc_control_if.sv
// Bundle between the fetch-control block and the pipeline: the decode/execute
// side drives the control and operand fields, pc_control drives the fetch
// address and the branch and halt status.
interface pc_control_if;
    logic        stall;
    logic        halt;
    logic [1:0]  branch;
    logic [2:0]  ccc;
    logic [2:0]  flags;
    logic [8:0]  imm_9bit;
    logic [15:0] reg_target;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        taken;
    logic        flush;
    logic        halted;
    logic [15:0] taken_count;

    // Pipeline side: drives decode/execute information and observes fetch state.
    modport master (
        output stall, halt, branch, ccc, flags, imm_9bit, reg_target,
        input  pc, pc_plus2, taken, flush, halted, taken_count
    );

    // PC control side.
    modport slave (
        input  stall, halt, branch, ccc, flags, imm_9bit, reg_target,
        output pc, pc_plus2, taken, flush, halted, taken_count
    );
endinterface

// File: rtl/pc_control.sv
// Program-counter control. Branches are resolved in the cycle they are
// presented and redirect fetch at the next edge. A taken branch raises
// taken/flush for one cycle. HLT freezes the PC until reset.
module pc_control (
    input  logic         clk,
    input  logic         rst,   // asynchronous, active-low
    pc_control_if.slave  bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [1:0] BR_B  = 2'b01;
    localparam logic [1:0] BR_BR = 2'b10;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] count_q, count_d;
    logic        taken_q, taken_d;

    logic        cond_met;
    logic [15:0] pc_plus2;
    logic [15:0] b_target;
    logic [15:0] br_target;
    logic        flag_n, flag_v, flag_z;

    assign flag_n = bus.flags[2];
    assign flag_v = bus.flags[1];
    assign flag_z = bus.flags[0];

    assign pc_plus2  = pc_q + 16'd2;
    // The word offset is sign-extended and then scaled to bytes; the sum wraps.
    assign b_target  = pc_plus2 + {{6{bus.imm_9bit[8]}}, bus.imm_9bit, 1'b0};
    assign br_target = {bus.reg_target[15:1], 1'b0};

    // Evaluate the branch condition code against the execute-stage flags.
    always_comb begin
        cond_met = 1'b0;
        case (bus.ccc)
            3'b000:  cond_met = ~flag_z;
            3'b001:  cond_met = flag_z;
            3'b010:  cond_met = ~flag_z & ~flag_n;
            3'b011:  cond_met = flag_n;
            3'b100:  cond_met = flag_z | (~flag_z & ~flag_n);
            3'b101:  cond_met = flag_n | flag_z;
            3'b110:  cond_met = flag_v;
            default: cond_met = 1'b1;
        endcase
    end

    // Next-state logic: halt has priority over a branch, stall freezes everything.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        taken_d = 1'b0;
        if (state_q == RUN && !bus.stall) begin
            if (bus.halt) begin
                state_d = HALT;
            end else if (bus.branch == BR_B && cond_met) begin
                pc_d    = b_target;
                taken_d = 1'b1;
                count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            end else if (bus.branch == BR_BR && cond_met) begin
                pc_d    = br_target;
                taken_d = 1'b1;
                count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            end else begin
                pc_d = pc_plus2;
            end
        end
    end

    // State, PC, taken flag and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= 16'h0000;
            count_q <= 16'h0000;
            taken_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            taken_q <= taken_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus2    = pc_plus2;
    assign bus.taken       = taken_q;
    assign bus.flush       = taken_q;
    assign bus.halted      = (state_q == HALT);
    assign bus.taken_count = count_q;

endmodule

// File: tb/tb_pc_control.sv
// Bench for pc_control: a table of single-branch vectors, hand-written
// multi-cycle sequences (reset, halt, stall, saturation), and random stimulus
// checked against a behavioural model.
module tb_pc_control;

    logic clk;
    logic rst;
    pc_control_if bus ();

    pc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    int m_pc;
    int m_count;
    bit m_halted;
    bit m_taken;

    typedef struct {
        logic [15:0] start_pc;
        logic        stall;
        logic        halt;
        logic [1:0]  branch;
        logic [2:0]  ccc;
        logic [2:0]  flags;   // {N,V,Z}
        logic [8:0]  imm;
        logic [15:0] rt;
        logic [15:0] exp_pc;
        logic        exp_taken;
    } vec_t;

    vec_t vec [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall      = 1'b0;
        bus.halt       = 1'b0;
        bus.branch     = 2'b00;
        bus.ccc        = 3'b000;
        bus.flags      = 3'b000;
        bus.imm_9bit   = 9'h000;
        bus.reg_target = 16'h0000;
    endtask

    function automatic bit cond_ok(logic [2:0] c, logic [2:0] f);
        bit n, v, z;
        n = f[2];
        v = f[1];
        z = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_pc     = 0;
        m_count  = 0;
        m_halted = 0;
        m_taken  = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int off;
        bit is_branch;
        m_taken = 0;
        if (m_halted || bus.stall) return;
        if (bus.halt) begin
            m_halted = 1;
            return;
        end
        is_branch = (bus.branch == 2'b01) || (bus.branch == 2'b10);
        if (is_branch && cond_ok(bus.ccc, bus.flags)) begin
            if (bus.branch == 2'b01) begin
                off = int'(bus.imm_9bit);
                if (bus.imm_9bit[8]) off -= 512;
                m_pc = ((m_pc + 2 + 2 * off) % 65536 + 65536) % 65536;
            end else begin
                m_pc = int'(bus.reg_target) - (int'(bus.reg_target) % 2);
            end
            m_taken = 1;
            if (m_count < 65535) m_count++;
        end else begin
            m_pc = (m_pc + 2) % 65536;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},          32'(bus.pc),          32'(m_pc));
        check({tag, ".pc_plus2"},    32'(bus.pc_plus2),    32'((m_pc + 2) % 65536));
        check({tag, ".taken"},       32'(bus.taken),       32'(m_taken));
        check({tag, ".flush"},       32'(bus.flush),       32'(m_taken));
        check({tag, ".halted"},      32'(bus.halted),      32'(m_halted));
        check({tag, ".taken_count"}, 32'(bus.taken_count), 32'(m_count));
    endtask

    // Pulse reset between clock edges and check the asynchronous clear.
    task automatic do_reset();
        idle();
        rst = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        #1;
        rst = 1'b1;
    endtask

    // Jump to an address with an always-taken register branch.
    task automatic load_pc(input logic [15:0] addr);
        idle();
        bus.branch     = 2'b10;
        bus.ccc        = 3'b111;
        bus.reg_target = addr;
        step();
        check("load_pc", 32'(bus.pc), 32'(addr));
        idle();
    endtask

    initial begin
        // start, stall, halt, branch, ccc, flags, imm, rt, exp_pc, exp_taken
        vec[0]  = '{16'h0010, 1'b0, 1'b0, 2'b01, 3'b001, 3'b001, 9'h1FE, 16'h0000, 16'h000E, 1'b1};
        vec[1]  = '{16'h0010, 1'b0, 1'b0, 2'b01, 3'b001, 3'b000, 9'h1FE, 16'h0000, 16'h0012, 1'b0};
        vec[2]  = '{16'h0100, 1'b0, 1'b0, 2'b10, 3'b111, 3'b000, 9'h000, 16'h1235, 16'h1234, 1'b1};
        vec[3]  = '{16'hFFFE, 1'b0, 1'b0, 2'b00, 3'b111, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0};
        vec[4]  = '{16'h0040, 1'b0, 1'b0, 2'b11, 3'b111, 3'b000, 9'h010, 16'h8888, 16'h0042, 1'b0};
        vec[5]  = '{16'h0040, 1'b0, 1'b0, 2'b01, 3'b010, 3'b000, 9'h004, 16'h0000, 16'h004A, 1'b1};
        vec[6]  = '{16'h0040, 1'b0, 1'b0, 2'b01, 3'b010, 3'b100, 9'h004, 16'h0000, 16'h0042, 1'b0};
        vec[7]  = '{16'h0040, 1'b0, 1'b0, 2'b01, 3'b011, 3'b100, 9'h100, 16'h0000, 16'hFE42, 1'b1};
        vec[8]  = '{16'h0040, 1'b0, 1'b0, 2'b01, 3'b100, 3'b100, 9'h004, 16'h0000, 16'h0042, 1'b0};
        vec[9]  = '{16'h0040, 1'b0, 1'b0, 2'b01, 3'b100, 3'b101, 9'h0FF, 16'h0000, 16'h0240, 1'b1};
        vec[10] = '{16'h0040, 1'b0, 1'b0, 2'b01, 3'b101, 3'b000, 9'h004, 16'h0000, 16'h0042, 1'b0};
        vec[11] = '{16'h0040, 1'b0, 1'b0, 2'b10, 3'b110, 3'b010, 9'h000, 16'hABCD, 16'hABCC, 1'b1};
        vec[12] = '{16'h0040, 1'b0, 1'b0, 2'b01, 3'b000, 3'b000, 9'h000, 16'h0000, 16'h0042, 1'b1};
        vec[13] = '{16'h0040, 1'b0, 1'b0, 2'b01, 3'b000, 3'b001, 9'h000, 16'h0000, 16'h0042, 1'b0};
        vec[14] = '{16'h0040, 1'b1, 1'b0, 2'b01, 3'b111, 3'b000, 9'h004, 16'h0000, 16'h0040, 1'b0};
        vec[15] = '{16'h0040, 1'b0, 1'b1, 2'b01, 3'b111, 3'b000, 9'h004, 16'h0000, 16'h0040, 1'b0};
        vec[16] = '{16'hFFFC, 1'b0, 1'b0, 2'b01, 3'b111, 3'b000, 9'h002, 16'h0000, 16'h0002, 1'b1};

        idle();
        model_reset();
        do_reset();

        // Sequential fetch from reset.
        for (int i = 1; i <= 3; i++) begin
            step();
            model_step();
            check_all($sformatf("seq%0d", i));
        end
        check("seq.pc_end", 32'(bus.pc), 32'h0006);

        // Table-driven single-branch vectors.
        foreach (vec[i]) begin
            do_reset();
            load_pc(vec[i].start_pc);
            bus.stall      = vec[i].stall;
            bus.halt       = vec[i].halt;
            bus.branch     = vec[i].branch;
            bus.ccc        = vec[i].ccc;
            bus.flags      = vec[i].flags;
            bus.imm_9bit   = vec[i].imm;
            bus.reg_target = vec[i].rt;
            step();
            check($sformatf("vec%0d.pc", i),    32'(bus.pc),    32'(vec[i].exp_pc));
            check($sformatf("vec%0d.taken", i), 32'(bus.taken), 32'(vec[i].exp_taken));
            check($sformatf("vec%0d.flush", i), 32'(bus.flush), 32'(vec[i].exp_taken));
            check($sformatf("vec%0d.halted", i), 32'(bus.halted), 32'(vec[i].halt));
        end

        // Branch reached by sequential fetch: counter, one-cycle taken pulse.
        do_reset();
        repeat (8) step();
        check("b_seq.pc0", 32'(bus.pc), 32'h0010);
        bus.branch   = 2'b01;
        bus.ccc      = 3'b001;
        bus.flags    = 3'b001;
        bus.imm_9bit = 9'h1FE;
        step();
        check("b_seq.pc",    32'(bus.pc),          32'h000E);
        check("b_seq.taken", 32'(bus.taken),       32'h1);
        check("b_seq.flush", 32'(bus.flush),       32'h1);
        check("b_seq.count", 32'(bus.taken_count), 32'h1);
        idle();
        step();
        check("b_seq.pc2",    32'(bus.pc),    32'h0010);
        check("b_seq.taken2", 32'(bus.taken), 32'h0);
        check("b_seq.flush2", 32'(bus.flush), 32'h0);

        // Stall with a taken branch: everything holds.
        bus.stall  = 1'b1;
        bus.branch = 2'b01;
        bus.ccc    = 3'b111;
        step();
        check("stall.pc",    32'(bus.pc),          32'h0010);
        check("stall.taken", 32'(bus.taken),       32'h0);
        check("stall.count", 32'(bus.taken_count), 32'h1);

        // Halt with simultaneous branch, then ignored stimulus, then reset.
        do_reset();
        repeat (16) step();
        bus.halt   = 1'b1;
        bus.branch = 2'b01;
        bus.ccc    = 3'b111;
        step();
        check("halt.pc",     32'(bus.pc),          32'h0020);
        check("halt.halted", 32'(bus.halted),      32'h1);
        check("halt.taken",  32'(bus.taken),       32'h0);
        check("halt.count",  32'(bus.taken_count), 32'h0);
        bus.halt       = 1'b0;
        bus.branch     = 2'b10;
        bus.reg_target = 16'h4444;
        repeat (3) step();
        check("halt.hold_pc",     32'(bus.pc),     32'h0020);
        check("halt.hold_halted", 32'(bus.halted), 32'h1);
        check("halt.hold_taken",  32'(bus.taken),  32'h0);
        do_reset();
        check("halt.exit", 32'(bus.halted), 32'h0);
        step();
        check("halt.first_pc", 32'(bus.pc), 32'h0002);

        // Reset asserted while a taken branch is pending.
        do_reset();
        load_pc(16'h0010);
        bus.branch   = 2'b01;
        bus.ccc      = 3'b111;
        bus.imm_9bit = 9'h004;
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid.pc",    32'(bus.pc),          32'h0000);
        check("rst_mid.count", 32'(bus.taken_count), 32'h0);
        step();
        check("rst_mid.hold_pc",    32'(bus.pc),    32'h0000);
        check("rst_mid.hold_taken", 32'(bus.taken), 32'h0);
        rst = 1'b1;
        idle();
        step();
        check("rst_mid.first_pc", 32'(bus.pc), 32'h0002);

        // Randomized stimulus against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) begin
                do_reset();
            end
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.halt       = ($urandom_range(0, 40) == 0);
            bus.branch     = 2'($urandom);
            bus.ccc        = 3'($urandom);
            bus.flags      = 3'($urandom);
            bus.imm_9bit   = 9'($urandom);
            bus.reg_target = 16'($urandom);
            model_step();
            step();
            check_all($sformatf("rand%0d", i));
        end

        // Counter saturation.
        do_reset();
        bus.branch     = 2'b10;
        bus.ccc        = 3'b111;
        bus.reg_target = 16'h0100;
        repeat (65534) step();
        check("sat.fffe", 32'(bus.taken_count), 32'hFFFE);
        step();
        check("sat.ffff", 32'(bus.taken_count), 32'hFFFF);
        step();
        check("sat.hold",  32'(bus.taken_count), 32'hFFFF);
        check("sat.taken", 32'(bus.taken),       32'h1);
        check("sat.pc",    32'(bus.pc),          32'h0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
